data_bus_master_mux: RTL and testbench



---
 rtl/data_bus_master_mux_if.sv | 22 ++
 rtl/data_bus_master_mux.sv | 167 ++++++++++++++++
 tb/tb_data_bus_master_mux.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_bus_master_mux_if.sv
// rtl/data_bus_master_mux_if.sv - OBI-style data bus interface used by the master mux ports
interface ibex_data_bus;
  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        rvalid;
  logic        err;
  logic [31:0] rdata;

  modport master (
    output req, addr, we, be, wdata,
    input  gnt, rvalid, err, rdata
  );

  modport slave (
    input  req, addr, we, be, wdata,
    output gnt, rvalid, err, rdata
  );
endinterface

// File: rtl/data_bus_master_mux.sv
// rtl/data_bus_master_mux.sv - two-master to one-slave data bus arbiter with in-order response routing
// Optional round-robin arbitration between the masters: define DATA_BUS_MASTER_MUX_ROUND_ROBIN_EN.
module data_bus_master_mux #(
  parameter int unsigned OUTSTANDING_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  ibex_data_bus.slave  m0_bus,
  ibex_data_bus.slave  m1_bus,
  ibex_data_bus.master s_bus,
  output logic         busy
);

  localparam int unsigned PTR_W = (OUTSTANDING_DEPTH > 1) ? $clog2(OUTSTANDING_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(OUTSTANDING_DEPTH + 1);

  // IDLE: free to arbitrate; LOCKED: a request is on the bus waiting for gnt
  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  arb_state_e state_q, state_d;

  // Selected master: 0 = m0 (core), 1 = m1 (secondary)
  logic sel_q, sel_d;
  logic sel_req;
  logic s_req;

  // ID FIFO remembering which master owns each granted-but-unanswered transaction
  logic [OUTSTANDING_DEPTH-1:0] id_mem_q;
  logic [PTR_W-1:0]             wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]             count_q;
  logic                         fifo_empty, fifo_full;
  logic                         push, pop;
  logic                         head_id;
  logic                         route0, route1;

`ifdef DATA_BUS_MASTER_MUX_ROUND_ROBIN_EN
  logic rr_ptr_q;
`endif

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(OUTSTANDING_DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(OUTSTANDING_DEPTH));
  assign head_id    = id_mem_q[rd_ptr_q];

  // Choose the master that drives the slave bus; frozen while a request waits for gnt
  always_comb begin
    sel_d = sel_q;
    if (state_q == ARB_IDLE) begin
      if (m0_bus.req && m1_bus.req) begin
`ifdef DATA_BUS_MASTER_MUX_ROUND_ROBIN_EN
        sel_d = rr_ptr_q;
`else
        sel_d = 1'b0;
`endif
      end else if (m0_bus.req) begin
        sel_d = 1'b0;
      end else if (m1_bus.req) begin
        sel_d = 1'b1;
      end
    end
  end

  assign sel_req = sel_d ? m1_bus.req : m0_bus.req;

  // A full FIFO blocks new requests unless a response frees a slot in the same cycle.
  // Gating with rst_n keeps the slave request quiet while reset is held.
  assign s_req = sel_req & ~(fifo_full & ~s_bus.rvalid) & rst_n;

  assign push = s_req & s_bus.gnt;
  assign pop  = s_bus.rvalid & ~fifo_empty;

  // Request path: straight combinational mux from the selected master
  assign s_bus.req   = s_req;
  assign s_bus.addr  = sel_d ? m1_bus.addr  : m0_bus.addr;
  assign s_bus.we    = sel_d ? m1_bus.we    : m0_bus.we;
  assign s_bus.be    = sel_d ? m1_bus.be    : m0_bus.be;
  assign s_bus.wdata = sel_d ? m1_bus.wdata : m0_bus.wdata;

  assign m0_bus.gnt = s_bus.gnt & s_req & ~sel_d;
  assign m1_bus.gnt = s_bus.gnt & s_req &  sel_d;

  // Response path: FIFO head names the owner; an empty FIFO drops spurious responses
  assign route0 = ~fifo_empty & ~head_id;
  assign route1 = ~fifo_empty &  head_id;

  assign m0_bus.rvalid = pop & ~head_id;
  assign m1_bus.rvalid = pop &  head_id;
  assign m0_bus.err    = route0 & s_bus.err;
  assign m1_bus.err    = route1 & s_bus.err;
  assign m0_bus.rdata  = route0 ? s_bus.rdata : 32'b0;
  assign m1_bus.rdata  = route1 ? s_bus.rdata : 32'b0;

  assign busy = ~fifo_empty | s_req;

  // Lock next-state: hold the selection while the slave has not granted the request
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: begin
        if (s_req && !s_bus.gnt) begin
          state_d = ARB_LOCKED;
        end
      end
      ARB_LOCKED: begin
        if (s_bus.gnt || !s_req) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Lock state and last selection registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  // ID FIFO: push the owner on every accepted grant, pop on every routed response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_mem_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        id_mem_q[wr_ptr_q] <= sel_d;
        wr_ptr_q           <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef DATA_BUS_MASTER_MUX_ROUND_ROBIN_EN
  // Round-robin pointer: hand priority to the other master after each accepted grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= 1'b0;
    end else if (push) begin
      rr_ptr_q <= ~rr_ptr_q;
    end
  end
`endif

endmodule

// File: tb/tb_data_bus_master_mux.sv
// tb/tb_data_bus_master_mux.sv - self-checking bench for data_bus_master_mux
module tb_data_bus_master_mux;

  localparam int DEPTH = 2;
`ifdef DATA_BUS_MASTER_MUX_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic busy;

  ibex_data_bus m0_if ();
  ibex_data_bus m1_if ();
  ibex_data_bus s_if ();

  data_bus_master_mux #(.OUTSTANDING_DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .m0_bus (m0_if),
    .m1_bus (m1_if),
    .s_bus  (s_if),
    .busy   (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_in(input logic r0, input logic [31:0] a0, input logic r1, input logic [31:0] a1,
                        input logic sg, input logic srv, input logic [31:0] srd);
    m0_if.req = r0; m0_if.addr = a0; m0_if.we = 1'b0; m0_if.be = 4'hf; m0_if.wdata = 32'h0;
    m1_if.req = r1; m1_if.addr = a1; m1_if.we = 1'b0; m1_if.be = 4'hf; m1_if.wdata = 32'h0;
    s_if.gnt = sg; s_if.rvalid = srv; s_if.rdata = srd; s_if.err = 1'b0;
  endtask

  task automatic do_reset();
    set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- behavioural reference model ----------------
  bit q[$];
  bit m_lock, m_sel, m_rr;
  bit e_sel, e_req, e_g0, e_g1, e_rv0, e_rv1, e_busy;

  task automatic model_reset();
    q.delete();
    m_lock = 1'b0;
    m_sel  = 1'b0;
    m_rr   = 1'b0;
  endtask

  task automatic model_eval();
    bit r0, r1, full;
    r0 = m0_if.req;
    r1 = m1_if.req;
    full = (q.size() == DEPTH);
    if (m_lock) e_sel = m_sel;
    else if (r0 && r1) e_sel = RR ? m_rr : 1'b0;
    else if (r0) e_sel = 1'b0;
    else if (r1) e_sel = 1'b1;
    else e_sel = m_sel;
    e_req = (e_sel ? r1 : r0) && !(full && s_if.rvalid == 1'b0);
    e_g0 = e_req && s_if.gnt && !e_sel;
    e_g1 = e_req && s_if.gnt && e_sel;
    e_rv0 = s_if.rvalid && q.size() > 0 && q[0] == 1'b0;
    e_rv1 = s_if.rvalid && q.size() > 0 && q[0] == 1'b1;
    e_busy = (q.size() > 0) || e_req;
  endtask

  task automatic model_commit();
    if (s_if.rvalid && q.size() > 0) void'(q.pop_front());
    if (e_req && s_if.gnt) begin
      q.push_back(e_sel);
      if (RR) m_rr = !m_rr;
    end
    m_lock = e_req && !s_if.gnt;
    m_sel = e_sel;
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic        r0;
    logic [31:0] a0;
    logic        r1;
    logic [31:0] a1;
    logic        sg;
    logic        srv;
    logic        x_req;
    logic [31:0] x_addr;
    logic        x_g0;
    logic        x_g1;
    logic        x_rv0;
    logic        x_rv1;
    logic        x_busy;
  } vec_t;

  vec_t vecs[8];

  bit           pend[2];
  logic [31:0]  pa[2], pd[2];
  logic [3:0]   pb[2];
  logic         pw[2];

  initial begin
    logic [72:0] act_r, exp_r;
    logic [67:0] act_s, exp_s;
    logic [37:0] act_v, exp_v;
    logic [31:0] srd;

    vecs[0] = {1'b0, 32'h0,    1'b0, 32'h0,    1'b1, 1'b0, 1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = {1'b1, 32'h1000, 1'b0, 32'h2000, 1'b1, 1'b0, 1'b1, 32'h1000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2] = {1'b0, 32'h1000, 1'b1, 32'h2000, 1'b1, 1'b0, 1'b1, 32'h2000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3] = {1'b1, 32'h1000, 1'b1, 32'h2000, 1'b1, 1'b0, 1'b1, 32'h1000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4] = {1'b1, 32'h1000, 1'b1, 32'h2000, 1'b0, 1'b0, 1'b1, 32'h1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5] = {1'b0, 32'h1000, 1'b1, 32'h2000, 1'b0, 1'b0, 1'b1, 32'h2000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[6] = {1'b0, 32'h0,    1'b0, 32'h2000, 1'b0, 1'b1, 1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7] = {1'b0, 32'h0,    1'b1, 32'h2000, 1'b1, 1'b1, 1'b1, 32'h2000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    // reset state, with a master and the slave active during reset
    rst_n = 1'b0;
    set_in(1'b1, 32'h44, 1'b1, 32'h88, 1'b1, 1'b1, 32'hFFFF_FFFF);
    s_if.err = 1'b1;
    #12;
    chk("rst_s_req", s_if.req, 1'b0);
    chk("rst_gnt", {m0_if.gnt, m1_if.gnt}, 2'b00);
    chk("rst_rvalid", {m0_if.rvalid, m1_if.rvalid}, 2'b00);
    chk("rst_err", {m0_if.err, m1_if.err}, 2'b00);
    chk("rst_rdata", {m0_if.rdata, m1_if.rdata}, 64'h0);
    chk("rst_busy", busy, 1'b0);
    tick();
    do_reset();

    // table-driven single-cycle checks, each from a fresh reset
    for (int i = 0; i < 8; i++) begin
      tick();
      do_reset();
      set_in(vecs[i].r0, vecs[i].a0, vecs[i].r1, vecs[i].a1, vecs[i].sg, vecs[i].srv, 32'h55);
      settle();
      act_v = {s_if.req, s_if.addr, m0_if.gnt, m1_if.gnt, m0_if.rvalid, m1_if.rvalid, busy};
      exp_v = {vecs[i].x_req, vecs[i].x_addr, vecs[i].x_g0, vecs[i].x_g1,
               vecs[i].x_rv0, vecs[i].x_rv1, vecs[i].x_busy};
      chk($sformatf("vec%0d", i), act_v, exp_v);
    end

    // m0 only read
    tick(); do_reset();
    set_in(1'b1, 32'h0000_1000, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0); settle();
    chk("m0_only_gnt", {m0_if.gnt, m1_if.gnt, busy}, 3'b101);
    tick();
    set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF); settle();
    chk("m0_only_rsp", {m0_if.rvalid, m1_if.rvalid, m0_if.rdata, busy}, {2'b10, 32'hDEAD_BEEF, 1'b1});
    tick();
    set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0); settle();
    chk("m0_only_idle_busy", busy, 1'b0);

    // simultaneous requests, m0 first
    tick(); do_reset();
    set_in(1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 1'b0, 32'h0); settle();
    chk("simul_c0", {s_if.addr, m0_if.gnt, m1_if.gnt}, {32'h100, 2'b10});
    tick();
    set_in(1'b0, 32'h100, 1'b1, 32'h200, 1'b1, 1'b1, 32'h11); settle();
    chk("simul_c1_req", {s_if.addr, m0_if.gnt, m1_if.gnt}, {32'h200, 2'b01});
    chk("simul_c1_rsp", {m0_if.rvalid, m1_if.rvalid, m0_if.rdata}, {2'b10, 32'h11});
    tick();
    set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h22); settle();
    chk("simul_c2_rsp", {m0_if.rvalid, m1_if.rvalid, m1_if.rdata, m0_if.rdata}, {2'b01, 32'h22, 32'h0});
    tick();
    set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0); settle();
    chk("simul_idle_busy", busy, 1'b0);

    // lock: m0 waits for gnt, m1 arrives later
    tick(); do_reset();
    for (int c = 0; c < 4; c++) begin
      set_in(1'b1, 32'h300, c >= 1, 32'h400, c == 3, 1'b0, 32'h0); settle();
      chk($sformatf("lockA_c%0d", c), {s_if.req, s_if.addr, m0_if.gnt, m1_if.gnt},
          {1'b1, 32'h300, c == 3, 1'b0});
      tick();
    end
    set_in(1'b0, 32'h0, 1'b1, 32'h400, 1'b1, 1'b0, 32'h0); settle();
    chk("lockA_after", {s_if.addr, m0_if.gnt, m1_if.gnt}, {32'h400, 2'b01});

    // lock: m1 waits for gnt, higher-priority m0 arrives later and must not steal the bus
    tick(); do_reset();
    for (int c = 0; c < 4; c++) begin
      set_in(c >= 1, 32'h600, 1'b1, 32'h500, c == 3, 1'b0, 32'h0); settle();
      chk($sformatf("lockB_c%0d", c), {s_if.req, s_if.addr, m0_if.gnt, m1_if.gnt},
          {1'b1, 32'h500, 1'b0, c == 3});
      tick();
    end
    set_in(1'b1, 32'h600, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0); settle();
    chk("lockB_after", {s_if.addr, m0_if.gnt, m1_if.gnt}, {32'h600, 2'b10});

    // FIFO full with depth 2
    tick(); do_reset();
    set_in(1'b1, 32'h10, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0); settle();
    chk("full_g1", m0_if.gnt, 1'b1);
    tick();
    set_in(1'b1, 32'h14, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0); settle();
    chk("full_g2", m0_if.gnt, 1'b1);
    tick();
    set_in(1'b1, 32'h18, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0); settle();
    chk("full_blocked", {s_if.req, m0_if.gnt, m1_if.gnt, busy}, 4'b0001);
    tick();
    set_in(1'b1, 32'h18, 1'b0, 32'h0, 1'b1, 1'b1, 32'hAA); settle();
    chk("full_pass", {s_if.req, m0_if.gnt, m0_if.rvalid, m0_if.rdata}, {3'b111, 32'hAA});
    tick();
    set_in(1'b1, 32'h1C, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0); settle();
    chk("full_still", {s_if.req, m0_if.gnt}, 2'b00);
    for (int c = 0; c < 3; c++) begin
      tick();
      set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hB0 + c); settle();
      chk($sformatf("full_drain%0d", c), {m0_if.rvalid, m1_if.rvalid, busy},
          {c < 2, 1'b0, c < 2});
    end

    // reset with two outstanding, then a late response
    tick(); do_reset();
    set_in(1'b1, 32'h20, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0); settle();
    tick();
    set_in(1'b0, 32'h0, 1'b1, 32'h24, 1'b1, 1'b0, 32'h0); settle();
    chk("rst_mid_g", m1_if.gnt, 1'b1);
    tick();
    set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b0; settle();
    chk("rst_mid_busy", busy, 1'b0);
    rst_n = 1'b1;
    s_if.rvalid = 1'b1; s_if.rdata = 32'h77; settle();
    chk("late_rsp", {m0_if.rvalid, m1_if.rvalid, busy}, 3'b000);
    tick();
    s_if.rvalid = 1'b0; settle();
    chk("late_busy", busy, 1'b0);
    set_in(1'b1, 32'h28, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0); settle();
    tick();
    set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h99); settle();
    chk("post_rst_rsp", {m0_if.rvalid, m1_if.rvalid, m0_if.rdata}, {2'b10, 32'h99});
    tick();
    set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0); settle();
    chk("post_rst_busy", busy, 1'b0);

    // both masters requesting continuously
    tick(); do_reset();
    for (int k = 0; k < 7; k++) begin
      set_in(k < 6, 32'hA0, k < 6, 32'hB0, 1'b1, k >= 1, 32'h1000 + k); settle();
      if (k < 6) begin
        if (RR) chk($sformatf("cont_g%0d", k), {m0_if.gnt, m1_if.gnt}, {k % 2 == 0, k % 2 == 1});
        else    chk($sformatf("cont_g%0d", k), {m0_if.gnt, m1_if.gnt}, 2'b10);
      end
      if (k >= 1) begin
        if (RR) chk($sformatf("cont_r%0d", k), {m0_if.rvalid, m1_if.rvalid}, {(k - 1) % 2 == 0, (k - 1) % 2 == 1});
        else    chk($sformatf("cont_r%0d", k), {m0_if.rvalid, m1_if.rvalid}, 2'b10);
      end
      tick();
    end

    // randomized traffic against the reference model
    tick(); do_reset(); model_reset();
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 700 == 699) begin
        do_reset(); model_reset();
        pend[0] = 1'b0; pend[1] = 1'b0;
      end
      for (int m = 0; m < 2; m++) begin
        if (!pend[m] && $urandom_range(0, 2) == 0) begin
          pend[m] = 1'b1;
          pa[m] = $urandom; pd[m] = $urandom;
          pb[m] = 4'($urandom); pw[m] = 1'($urandom);
        end
      end
      m0_if.req = pend[0]; m0_if.addr = pa[0]; m0_if.we = pw[0]; m0_if.be = pb[0]; m0_if.wdata = pd[0];
      m1_if.req = pend[1]; m1_if.addr = pa[1]; m1_if.we = pw[1]; m1_if.be = pb[1]; m1_if.wdata = pd[1];
      s_if.gnt = ($urandom_range(0, 9) < 6);
      s_if.rvalid = (q.size() > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 19) == 0);
      srd = $urandom;
      s_if.rdata = srd;
      s_if.err = ($urandom_range(0, 7) == 0);
      settle();
      model_eval();
      act_r = {s_if.req, s_if.req ? {s_if.addr, s_if.we, s_if.be, s_if.wdata} : 69'b0,
               m0_if.gnt, m1_if.gnt, busy};
      exp_r = {e_req, e_req ? {pa[e_sel], pw[e_sel], pb[e_sel], pd[e_sel]} : 69'b0,
               e_g0, e_g1, e_busy};
      chk($sformatf("rand_req_c%0d", cyc), act_r, exp_r);
      act_s = {m0_if.rvalid, m1_if.rvalid,
               (m0_if.rvalid | m1_if.rvalid) ? {m0_if.err, m1_if.err, m0_if.rdata, m1_if.rdata} : 66'b0};
      exp_s = {e_rv0, e_rv1,
               (e_rv0 | e_rv1) ? {e_rv0 & s_if.err, e_rv1 & s_if.err,
                                  e_rv0 ? srd : 32'h0, e_rv1 ? srd : 32'h0} : 66'b0};
      chk($sformatf("rand_rsp_c%0d", cyc), act_s, exp_s);
      model_commit();
      if (e_g0) pend[0] = 1'b0;
      if (e_g1) pend[1] = 1'b0;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
